// File: rtl/cnn_pkg.sv
// Shared types and constants for the handwritten-digit frame sequencer.
package cnn_pkg;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t StIdle   = 2'd0;
  localparam seq_state_t StStream = 2'd1;
  localparam seq_state_t StWait   = 2'd2;
  localparam seq_state_t StFlush  = 2'd3;

  localparam int unsigned CanvasWDefault = 30;
  localparam int unsigned ImgWDefault    = 28;

  localparam logic [7:0] PIX_ON  = 8'hFF;
  localparam logic [7:0] PIX_OFF = 8'h00;

endpackage

// File: rtl/canvas_crop_reader.sv
// Holds the canvas snapshot taken at pass start and maps a crop coordinate to its pixel value.
module canvas_crop_reader
  import cnn_pkg::*;
#(
  parameter int unsigned CANVAS_W = CanvasWDefault,
  parameter int unsigned IMG_W    = ImgWDefault
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           load_i,
  input  logic [CANVAS_W*CANVAS_W-1:0]   canvas_i,
  input  logic [$clog2(IMG_W)-1:0]       row_i,
  input  logic [$clog2(IMG_W)-1:0]       col_i,
  output logic [7:0]                     pixel_o
);

  localparam int unsigned Off  = (CANVAS_W - IMG_W) / 2;
  localparam int unsigned IdxW = $clog2(CANVAS_W * CANVAS_W);

  logic [CANVAS_W*CANVAS_W-1:0] snap_q, snap_d;
  logic [IdxW-1:0]              pix_idx;

  always_comb begin
    snap_d = load_i ? canvas_i : snap_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      snap_q <= '0;
    end else begin
      snap_q <= snap_d;
    end
  end

  // Crop window is centred: crop (r,c) sits at canvas (r+Off, c+Off).
  always_comb begin
    pix_idx = (IdxW'(row_i) + IdxW'(Off)) * IdxW'(CANVAS_W) + IdxW'(col_i) + IdxW'(Off);
    pixel_o = snap_q[pix_idx] ? PIX_ON : PIX_OFF;
  end

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Runs one recognition pass: snapshot canvas, stream the 28x28 crop to the CNN, await its digit.
module cnn_frame_sequencer
  import cnn_pkg::*;
#(
  parameter int unsigned CANVAS_W       = CanvasWDefault,
  parameter int unsigned IMG_W          = ImgWDefault,
  parameter int unsigned PIXEL_GAP      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned CNN_RST_CYCLES = 4,
  parameter bit          AUTO_CLEAR     = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CANVAS_W*CANVAS_W-1:0] i_canvas,
  input  logic                         i_start,
  input  logic                         i_abort,
  output logic [7:0]                   o_pixel,
  output logic                         o_pixel_valid,
  input  logic [3:0]                   i_cnn_digit,
  input  logic                         i_cnn_digit_valid,
  output logic                         o_cnn_rst,
  output logic [3:0]                   o_digit,
  output logic                         o_digit_valid,
  output logic                         o_busy,
  output logic                         o_timeout,
  output logic                         o_canvas_clear
);

  localparam int unsigned CoordW = $clog2(IMG_W);
  localparam int unsigned GapW   = (PIXEL_GAP > 0) ? $clog2(PIXEL_GAP + 1) : 1;
  localparam int unsigned TmoW   = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned FlW    = (CNN_RST_CYCLES > 1) ? $clog2(CNN_RST_CYCLES) : 1;

  localparam logic [CoordW-1:0] LastCoord = CoordW'(IMG_W - 1);
  localparam logic [GapW-1:0]   GapLast   = GapW'(PIXEL_GAP);
  localparam logic [TmoW-1:0]   TmoLast   = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [FlW-1:0]    FlushLast = FlW'(CNN_RST_CYCLES - 1);

  seq_state_t        state_q, state_d;
  logic [CoordW-1:0] row_q, row_d, col_q, col_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [FlW-1:0]    flush_q, flush_d;
  logic [3:0]        digit_q, digit_d;
  logic              digit_valid_q, digit_valid_d;
  logic              clear_q, clear_d;
  logic              load;
  logic              timeout;

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    gap_d         = gap_q;
    tmo_d         = tmo_q;
    flush_d       = flush_q;
    digit_d       = digit_q;
    digit_valid_d = 1'b0;
    clear_d       = 1'b0;
    load          = 1'b0;
    timeout       = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_start && !i_abort) begin
          load    = 1'b1;
          row_d   = '0;
          col_d   = '0;
          gap_d   = '0;
          state_d = StStream;
        end
      end
      StStream: begin
        if (i_abort) begin
          flush_d = '0;
          state_d = StFlush;
        end else if (gap_q != GapLast) begin
          gap_d = gap_q + 1'b1;
        end else begin
          // Pixel slot (strobe plus its trailing gap) is over; step the raster position.
          gap_d = '0;
          if (col_q != LastCoord) begin
            col_d = col_q + 1'b1;
          end else if (row_q != LastCoord) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            tmo_d   = '0;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (i_abort) begin
          flush_d = '0;
          state_d = StFlush;
        end else if (i_cnn_digit_valid) begin
          digit_d       = i_cnn_digit;
          digit_valid_d = 1'b1;
          clear_d       = AUTO_CLEAR;
          state_d       = StIdle;
        end else if (tmo_q == TmoLast) begin
          timeout = 1'b1;
          flush_d = '0;
          state_d = StFlush;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StFlush: begin
        if (flush_q == FlushLast) begin
          state_d = StIdle;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      row_q         <= '0;
      col_q         <= '0;
      gap_q         <= '0;
      tmo_q         <= '0;
      flush_q       <= '0;
      digit_q       <= 4'd0;
      digit_valid_q <= 1'b0;
      clear_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      gap_q         <= gap_d;
      tmo_q         <= tmo_d;
      flush_q       <= flush_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      clear_q       <= clear_d;
    end
  end

  canvas_crop_reader #(
    .CANVAS_W (CANVAS_W),
    .IMG_W    (IMG_W)
  ) u_reader (
    .clk_i    (clk),
    .rst_i    (rst),
    .load_i   (load),
    .canvas_i (i_canvas),
    .row_i    (row_q),
    .col_i    (col_q),
    .pixel_o  (o_pixel)
  );

  always_comb begin
    o_pixel_valid  = (state_q == StStream) && (gap_q == '0);
    o_cnn_rst      = (state_q == StFlush);
    o_busy         = (state_q != StIdle);
    o_timeout      = timeout;
    o_digit        = digit_q;
    o_digit_valid  = digit_valid_q;
    o_canvas_clear = clear_q;
  end

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Bench for cnn_frame_sequencer: two instances (gap 0 and gap 2) checked against a phase model.
module tb_cnn_frame_sequencer;

  localparam int Tmo   = 100;
  localparam int NPix  = 784;
  localparam int MIdle = 0, MStream = 1, MWait = 2, MFlush = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [899:0] i_canvas = '0;
  logic         i_start = 1'b0, i_abort = 1'b0, dvin = 1'b0;
  logic [3:0]   digin = 4'd0;

  logic [7:0] pix [2];
  logic       pv [2], crst [2], busy [2], tmo [2], dv [2], clr [2];
  logic [3:0] dig [2];

  always #20 clk = ~clk;

  cnn_frame_sequencer #(.PIXEL_GAP(0), .TIMEOUT_CYCLES(Tmo)) dut0 (
    .clk(clk), .rst(rst), .i_canvas(i_canvas), .i_start(i_start), .i_abort(i_abort),
    .o_pixel(pix[0]), .o_pixel_valid(pv[0]), .i_cnn_digit(digin), .i_cnn_digit_valid(dvin),
    .o_cnn_rst(crst[0]), .o_digit(dig[0]), .o_digit_valid(dv[0]), .o_busy(busy[0]),
    .o_timeout(tmo[0]), .o_canvas_clear(clr[0])
  );

  cnn_frame_sequencer #(.PIXEL_GAP(2), .TIMEOUT_CYCLES(Tmo)) dut2 (
    .clk(clk), .rst(rst), .i_canvas(i_canvas), .i_start(i_start), .i_abort(i_abort),
    .o_pixel(pix[1]), .o_pixel_valid(pv[1]), .i_cnn_digit(digin), .i_cnn_digit_valid(dvin),
    .o_cnn_rst(crst[1]), .o_digit(dig[1]), .o_digit_valid(dv[1]), .o_busy(busy[1]),
    .o_timeout(tmo[1]), .o_canvas_clear(clr[1])
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  // Stream index k maps to canvas (k/28 + 1, k%28 + 1).
  function automatic logic [7:0] crop(input logic [899:0] s, input int k);
    int r, c;
    r = k / 28;
    c = k % 28;
    return s[(r + 1) * 30 + c + 1] ? 8'hFF : 8'h00;
  endfunction

  // Model: phase plus cycles elapsed in that phase, per instance.
  int           m_mode [2];
  int           m_n [2];
  logic [899:0] m_snap [2];
  logic [3:0]   m_digit [2];
  logic         m_dv [2], m_clr [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_dv[i]  <= 1'b0;
      m_clr[i] <= 1'b0;
      if (rst) begin
        m_mode[i]  <= MIdle;
        m_n[i]     <= 0;
        m_snap[i]  <= '0;
        m_digit[i] <= 4'd0;
      end else if (m_mode[i] == MIdle) begin
        if (i_start && !i_abort) begin
          m_snap[i] <= i_canvas;
          m_mode[i] <= MStream;
          m_n[i]    <= 0;
        end
      end else if (m_mode[i] == MStream) begin
        if (i_abort) begin
          m_mode[i] <= MFlush;
          m_n[i]    <= 0;
        end else if (m_n[i] == NPix * (gap_of(i) + 1) - 1) begin
          m_mode[i] <= MWait;
          m_n[i]    <= 0;
        end else begin
          m_n[i] <= m_n[i] + 1;
        end
      end else if (m_mode[i] == MWait) begin
        if (i_abort) begin
          m_mode[i] <= MFlush;
          m_n[i]    <= 0;
        end else if (dvin) begin
          m_digit[i] <= digin;
          m_dv[i]    <= 1'b1;
          m_clr[i]   <= 1'b1;
          m_mode[i]  <= MIdle;
        end else if (m_n[i] == Tmo - 1) begin
          m_mode[i] <= MFlush;
          m_n[i]    <= 0;
        end else begin
          m_n[i] <= m_n[i] + 1;
        end
      end else begin
        if (m_n[i] == 3) m_mode[i] <= MIdle;
        else m_n[i] <= m_n[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("dut%0d ctrl{busy,valid,cnnrst,tmo,dv,clr,digit}", i),
            {22'd0, busy[i], pv[i], crst[i], tmo[i], dv[i], clr[i], dig[i]},
            {22'd0, m_mode[i] != MIdle,
             m_mode[i] == MStream && (m_n[i] % (gap_of(i) + 1)) == 0,
             m_mode[i] == MFlush,
             m_mode[i] == MWait && m_n[i] == Tmo - 1 && !dvin && !i_abort,
             m_dv[i], m_clr[i], m_digit[i]});
        if (m_mode[i] == MStream)
          chk($sformatf("dut%0d pixel", i), 32'(pix[i]),
              32'(crop(m_snap[i], m_n[i] / (gap_of(i) + 1))));
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_idle(input int which);
    int n;
    n = 0;
    while (busy[which] && n < 6000) begin
      nxt();
      smp();
      n++;
    end
    chk($sformatf("dut%0d returns to idle", which), 32'(busy[which]), 32'd0);
  endtask

  function automatic logic [899:0] mk_diag();
    logic [899:0] v;
    v = '0;
    for (int i = 0; i < 30; i++) v[i * 30 + i] = 1'b1;
    return v;
  endfunction

  function automatic logic [899:0] mk_border();
    logic [899:0] v;
    v = '0;
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 30; x++)
        if (x == 0 || x == 29 || y == 0 || y == 29) v[y * 30 + x] = 1'b1;
    return v;
  endfunction

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int ones, strobes;
    nxt();
    chk_en = 1'b1;
    nxt();
    rst = 1'b0;
    smp();
    chk("reset busy", 32'(busy[0]), 0);
    chk("reset valid", 32'(pv[0]), 0);
    chk("reset pixel", 32'(pix[0]), 0);
    chk("reset digit", 32'(dig[0]), 0);
    chk("reset cnn_rst", 32'(crst[0]), 0);

    // Diagonal canvas, gap 0; a stray start mid-stream must be ignored.
    nxt(); i_canvas = mk_diag(); i_start = 1'b1;
    nxt(); i_start = 1'b0;
    ones = 0;
    for (int k = 0; k < NPix; k++) begin
      smp();
      chk("diag valid", 32'(pv[0]), 1);
      chk("diag pixel", 32'(pix[0]), (k % 29 == 0) ? 32'hFF : 32'h00);
      if (pix[0] == 8'hFF) ones++;
      nxt();
      i_start = (k == 100);
    end
    smp();
    chk("diag valid after last", 32'(pv[0]), 0);
    chk("diag ones count", 32'(ones), 28);
    repeat (48) nxt();
    digin = 4'd7; dvin = 1'b1;
    nxt(); dvin = 1'b0;
    smp();
    chk("result digit", 32'(dig[0]), 7);
    chk("result pulse", 32'(dv[0]), 1);
    chk("result clear", 32'(clr[0]), 1);
    chk("result busy", 32'(busy[0]), 0);
    nxt(); smp();
    chk("result pulse width", 32'(dv[0]), 0);
    wait_idle(1);

    // All-ones canvas on the gap-2 instance.
    nxt(); i_canvas = '1; i_start = 1'b1;
    nxt(); i_start = 1'b0;
    strobes = 0;
    for (int j = 0; j < NPix * 3; j++) begin
      smp();
      chk("gap2 valid", 32'(pv[1]), (j % 3 == 0) ? 32'd1 : 32'd0);
      if (pv[1]) begin
        strobes++;
        chk("gap2 pixel", 32'(pix[1]), 32'hFF);
      end
      nxt();
    end
    smp();
    chk("gap2 valid after stream", 32'(pv[1]), 0);
    chk("gap2 strobe count", 32'(strobes), NPix);
    wait_idle(1);
    wait_idle(0);

    // Border-only canvas streams zeros, then no CNN answer: timeout.
    nxt(); i_canvas = mk_border(); i_start = 1'b1;
    nxt(); i_start = 1'b0;
    for (int k = 0; k < NPix; k++) begin
      smp();
      chk("border pixel", 32'(pix[0]), 0);
      nxt();
    end
    for (int w = 1; w <= Tmo; w++) begin
      smp();
      chk("timeout pulse", 32'(tmo[0]), (w == Tmo) ? 32'd1 : 32'd0);
      if (w == Tmo) chk("timeout keeps digit", 32'(dig[0]), 7);
      nxt();
    end
    for (int f = 0; f < 4; f++) begin
      smp();
      chk("flush cnn_rst", 32'(crst[0]), 1);
      nxt();
    end
    smp();
    chk("flush done cnn_rst", 32'(crst[0]), 0);
    chk("flush done busy", 32'(busy[0]), 0);
    wait_idle(1);

    // Abort while pixel 300 is on the bus.
    nxt(); i_canvas = mk_diag(); i_start = 1'b1;
    nxt(); i_start = 1'b0;
    repeat (300) nxt();
    i_abort = 1'b1;
    smp();
    chk("abort pixel300 valid", 32'(pv[0]), 1);
    nxt(); i_abort = 1'b0;
    smp();
    chk("abort valid drop", 32'(pv[0]), 0);
    chk("abort cnn_rst", 32'(crst[0]), 1);
    repeat (3) begin
      nxt(); smp();
      chk("abort cnn_rst hold", 32'(crst[0]), 1);
    end
    nxt(); smp();
    chk("abort back idle", 32'(busy[0]), 0);
    nxt(); digin = 4'd5; dvin = 1'b1;
    nxt(); dvin = 1'b0;
    smp();
    chk("stray strobe no pulse", 32'(dv[0]), 0);
    chk("stray strobe digit", 32'(dig[0]), 7);

    // Digit strobe on the timeout-expiry cycle: digit wins.
    nxt(); i_start = 1'b1;
    nxt(); i_start = 1'b0;
    repeat (NPix) nxt();
    repeat (Tmo - 1) nxt();
    digin = 4'd3; dvin = 1'b1;
    smp();
    chk("coincident no timeout", 32'(tmo[0]), 0);
    nxt(); dvin = 1'b0;
    smp();
    chk("coincident digit", 32'(dig[0]), 3);
    chk("coincident pulse", 32'(dv[0]), 1);
    chk("coincident busy", 32'(busy[0]), 0);
    wait_idle(1);

    // Canvas flipped mid-stream, then reset mid-stream.
    nxt(); i_canvas = mk_diag(); i_start = 1'b1;
    nxt(); i_start = 1'b0;
    repeat (10) nxt();
    i_canvas = ~mk_diag();
    repeat (19) nxt();
    smp();
    chk("snapshot pixel29", 32'(pix[0]), 32'hFF);
    nxt(); smp();
    chk("snapshot pixel30", 32'(pix[0]), 32'h00);
    repeat (100) nxt();
    rst = 1'b1;
    nxt(); rst = 1'b0;
    smp();
    chk("midreset pixel", 32'(pix[0]), 0);
    chk("midreset valid", 32'(pv[0]), 0);
    chk("midreset busy", 32'(busy[0]), 0);
    chk("midreset digit", 32'(dig[0]), 0);

    // Held start re-triggers on the first idle cycle after a flush.
    nxt(); i_canvas = mk_diag(); i_start = 1'b1;
    repeat (5) nxt();
    i_abort = 1'b1;
    nxt(); i_abort = 1'b0;
    repeat (4) nxt();
    smp();
    chk("held start idle gap", 32'(busy[0]), 0);
    nxt(); smp();
    chk("held start retrigger", 32'(pv[0]), 1);
    i_start = 1'b0;
    i_abort = 1'b1;
    nxt(); i_abort = 1'b0;
    wait_idle(0);
    wait_idle(1);

    repeat (3) nxt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
